camera_tracker: RTL and testbench

- Upstream stage of the pixel generator. Produces the registered camera_y block index and camera_offset that the renderer subtracts from absolute Y coordinates.
- Once per frame, at the vblank_start pulse, it samples the character's absolute Y.
- It finds the screen-block index of the character's centre with an iterative subtract divider, applies hysteresis, and commits the new camera only during blanking, so the picture never tears mid-frame.

---
 rtl/camera_tracker_if.sv | 30 +++
 rtl/camera_tracker.sv | 127 ++++++++++++
 tb/tb_camera_tracker.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/camera_tracker_if.sv
// rtl/camera_tracker_if.sv - signal bundle between the frame source and the camera tracker
//
// Purpose: groups the per-frame request (vblank_start, char_abs_y) and the
// committed camera results into one bundle.
// Modports:
//   master - frame source side: drives vblank_start, char_abs_y; observes results
//   slave  - camera_tracker side: samples the request, drives camera_y,
//            camera_offset, camera_update, busy, sat
interface camera_tracker_if #(
   parameter int PHY_WIDTH = 14,
   parameter int CAM_WIDTH = 5
);
   logic                 vblank_start;
   logic [PHY_WIDTH-1:0] char_abs_y;
   logic [CAM_WIDTH-1:0] camera_y;
   logic [PHY_WIDTH-1:0] camera_offset;
   logic                 camera_update;
   logic                 busy;
   logic                 sat;

   modport master (
      output vblank_start, char_abs_y,
      input  camera_y, camera_offset, camera_update, busy, sat
   );

   modport slave (
      input  vblank_start, char_abs_y,
      output camera_y, camera_offset, camera_update, busy, sat
   );
endinterface

// File: rtl/camera_tracker.sv
// rtl/camera_tracker.sv - per-frame camera block tracker with blanking-only commit
//
// Purpose: at each vblank_start pulse, samples the character's absolute Y,
// divides its centre by BLOCK_HEIGHT with a one-step-per-cycle subtract
// divider, and commits the new camera block (with optional hysteresis)
// while still inside vertical blanking.
// Optional feature macro: CAMERA_HYST_EN (hysteresis test in DECIDE).
// Ports:
//   sys_clk  - system clock
//   sys_rst  - asynchronous reset, active-high
//   ifc      - camera_tracker_if.slave:
//              vblank_start (in), char_abs_y (in), camera_y (out),
//              camera_offset (out), camera_update (out), busy (out), sat (out)
module camera_tracker #(
   parameter int PHY_WIDTH    = 14,
   parameter int BLOCK_HEIGHT = 480,
   parameter int CHAR_WIDTH_Y = 32,
   parameter int CAM_WIDTH    = 5,
   parameter int MAX_CAMERA_Y = 31,
   parameter int HYST         = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   camera_tracker_if.slave  ifc
);

   localparam logic [PHY_WIDTH:0]   BLOCK_R   = (PHY_WIDTH+1)'(BLOCK_HEIGHT);
   localparam logic [PHY_WIDTH:0]   HALF_CHAR = (PHY_WIDTH+1)'(CHAR_WIDTH_Y / 2);
   localparam logic [PHY_WIDTH:0]   HYST_LO   = (PHY_WIDTH+1)'(HYST);
   localparam logic [PHY_WIDTH:0]   HYST_HI   = (PHY_WIDTH+1)'(BLOCK_HEIGHT - 1 - HYST);
   localparam logic [PHY_WIDTH-1:0] BLOCK_P   = PHY_WIDTH'(BLOCK_HEIGHT);
   localparam logic [CAM_WIDTH-1:0] Q_MAX     = CAM_WIDTH'(MAX_CAMERA_Y);

`ifdef CAMERA_HYST_EN
   localparam bit HYST_ON = 1'b1;
`else
   localparam bit HYST_ON = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, DIVIDE, DECIDE} state_t;

   state_t               state;
   logic [PHY_WIDTH:0]   rem;
   logic [CAM_WIDTH-1:0] q;
   logic                 q_sat;      // this divide stopped on the saturation limit
   logic [CAM_WIDTH-1:0] cam_q;
   logic [PHY_WIDTH-1:0] cam_off;
   logic                 upd_q;
   logic                 busy_q;
   logic                 sat_q;

   logic [PHY_WIDTH:0]   centre;
   logic [PHY_WIDTH-1:0] offset_next;
   logic                 hyst_ok;
   logic                 commit;

   // One extra bit so the centre of a character near the top of the
   // coordinate range cannot wrap.
   assign centre      = {1'b0, ifc.char_abs_y} + HALF_CHAR;
   assign offset_next = PHY_WIDTH'(q) * BLOCK_P;

   // A saturated quotient bypasses hysteresis: rem is then not a true
   // remainder and would make the test meaningless.
   always_comb begin
      hyst_ok = 1'b0;
      commit  = 1'b0;
      hyst_ok = ((q > cam_q) && (rem >= HYST_LO)) ||
                ((q < cam_q) && (rem <= HYST_HI));
      commit  = (q != cam_q) && (q_sat || !HYST_ON || hyst_ok);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state   <= IDLE;
         rem     <= '0;
         q       <= '0;
         q_sat   <= 1'b0;
         cam_q   <= '0;
         cam_off <= '0;
         upd_q   <= 1'b0;
         busy_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               upd_q <= 1'b0;
               if (ifc.vblank_start) begin
                  rem    <= centre;
                  q      <= '0;
                  q_sat  <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= DIVIDE;
               end
            end
            DIVIDE: begin
               if (q == Q_MAX) begin
                  sat_q <= 1'b1;
                  q_sat <= 1'b1;
                  state <= DECIDE;
               end else if (rem >= BLOCK_R) begin
                  rem <= rem - BLOCK_R;
                  q   <= q + CAM_WIDTH'(1);
               end else begin
                  state <= DECIDE;
               end
            end
            DECIDE: begin
               if (commit) begin
                  cam_q   <= q;
                  cam_off <= offset_next;
                  upd_q   <= 1'b1;
               end
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ifc.camera_y      = cam_q;
   assign ifc.camera_offset = cam_off;
   assign ifc.camera_update = upd_q;
   assign ifc.busy          = busy_q;
   assign ifc.sat           = sat_q;

endmodule

// File: tb/tb_camera_tracker.sv
// tb/tb_camera_tracker.sv - directed self-checking bench for camera_tracker
module tb_camera_tracker;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

`ifdef CAMERA_HYST_EN
   localparam bit H = 1'b1;
`else
   localparam bit H = 1'b0;
`endif

   camera_tracker_if #(.PHY_WIDTH(14), .CAM_WIDTH(5)) ifc ();

   camera_tracker dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .ifc     (ifc)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, ".camera_y"},      32'(ifc.camera_y),      32'd0);
      chk({tag, ".camera_offset"}, 32'(ifc.camera_offset), 32'd0);
      chk({tag, ".busy"},          32'(ifc.busy),          32'd0);
      chk({tag, ".sat"},           32'(ifc.sat),           32'd0);
      chk({tag, ".camera_update"}, 32'(ifc.camera_update), 32'd0);
   endtask

   // One frame: pulse in cycle T, busy for T+1..T+q+2, result visible at T+q+3.
   task automatic frame(input string tag, input logic [13:0] y, input int q,
                        input logic commit, input logic [4:0] cam, input logic [13:0] off);
      @(negedge sys_clk);
      ifc.vblank_start = 1'b1;
      ifc.char_abs_y   = y;
      @(negedge sys_clk);
      ifc.vblank_start = 1'b0;
      ifc.char_abs_y   = ~y;               // must not disturb the sampled value
      for (int i = 1; i <= q + 2; i++) begin
         chk({tag, ".busy"}, 32'(ifc.busy), 32'd1);
         chk({tag, ".upd_early"}, 32'(ifc.camera_update), 32'd0);
         @(negedge sys_clk);
      end
      chk({tag, ".busy_done"},     32'(ifc.busy),          32'd0);
      chk({tag, ".camera_update"}, 32'(ifc.camera_update), 32'(commit));
      chk({tag, ".camera_y"},      32'(ifc.camera_y),      32'(cam));
      chk({tag, ".camera_offset"}, 32'(ifc.camera_offset), 32'(off));
      @(negedge sys_clk);
      chk({tag, ".upd_one_cycle"}, 32'(ifc.camera_update), 32'd0);
   endtask

   initial begin
      int busy_cnt;
      int upd_cnt;

      ifc.vblank_start = 1'b0;
      ifc.char_abs_y   = '0;

      // reset state
      repeat (2) @(negedge sys_clk);
      chk_outputs_zero("reset");
      sys_rst = 1'b0;
      @(negedge sys_clk);

      // centre 1016 -> q=2 rem=56
      frame("f1000", 14'd1000, 2, 1'b1, 5'd2, 14'd960);
      // centre 1446 -> q=3 rem=6 (below hysteresis margin)
      frame("f1430", 14'd1430, 3, !H, H ? 5'd2 : 5'd3, H ? 14'd960 : 14'd1440);
      // back to block 2 (no-op when hysteresis held it there)
      frame("f1000b", 14'd1000, 2, !H, 5'd2, 14'd960);
      // centre 956 -> q=1 rem=476 (above 463)
      frame("f940", 14'd940, 1, !H, H ? 5'd2 : 5'd1, H ? 14'd960 : 14'd480);
      frame("f1000c", 14'd1000, 2, !H, 5'd2, 14'd960);
      // centre 916 -> q=1 rem=436
      frame("f900", 14'd900, 1, 1'b1, 5'd1, 14'd480);
      chk("sat_before", 32'(ifc.sat), 32'd0);

      // centre 16399 -> saturates at q=31
      frame("fsat", 14'd16383, 31, 1'b1, 5'd31, 14'd14880);
      chk("sat_set", 32'(ifc.sat), 32'd1);
      // centre 16 -> q=0, sat stays sticky
      frame("f0", 14'd0, 0, 1'b1, 5'd0, 14'd0);
      chk("sat_sticky", 32'(ifc.sat), 32'd1);

      // back-to-back pulses: second one lands while busy and is dropped
      @(negedge sys_clk);
      ifc.vblank_start = 1'b1;
      ifc.char_abs_y   = 14'd1000;
      @(negedge sys_clk);
      chk("dbl.busy_t1", 32'(ifc.busy), 32'd1);
      @(negedge sys_clk);
      ifc.vblank_start = 1'b0;
      busy_cnt = 1;
      upd_cnt  = 0;
      for (int i = 0; i < 40; i++) begin
         if (ifc.busy) busy_cnt++;
         if (ifc.camera_update) upd_cnt++;
         @(negedge sys_clk);
      end
      chk("dbl.busy_cycles", 32'(busy_cnt), 32'd4);
      chk("dbl.updates", 32'(upd_cnt), 32'd1);
      chk("dbl.camera_y", 32'(ifc.camera_y), 32'd2);
      chk("dbl.camera_offset", 32'(ifc.camera_offset), 32'd960);

      // same position next frame -> no pulse
      frame("fsame", 14'd1000, 2, 1'b0, 5'd2, 14'd960);

      // asynchronous reset in the middle of a divide
      @(negedge sys_clk);
      ifc.vblank_start = 1'b1;
      ifc.char_abs_y   = 14'd16383;
      @(negedge sys_clk);
      ifc.vblank_start = 1'b0;
      repeat (4) @(negedge sys_clk);
      chk("rstmid.busy_before", 32'(ifc.busy), 32'd1);
      #2 sys_rst = 1'b1;
      #1 chk_outputs_zero("rstmid");
      @(negedge sys_clk);
      sys_rst  = 1'b0;
      busy_cnt = 0;
      upd_cnt  = 0;
      for (int i = 0; i < 40; i++) begin
         if (ifc.busy) busy_cnt++;
         if (ifc.camera_update) upd_cnt++;
         @(negedge sys_clk);
      end
      chk("rstmid.busy_after", 32'(busy_cnt), 32'd0);
      chk("rstmid.updates_after", 32'(upd_cnt), 32'd0);
      chk("rstmid.camera_y_after", 32'(ifc.camera_y), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
